// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel hobby-servo PWM generator.
// One shared frame counter drives NUM_CH channels. Each channel slews its current
// position toward a target (written over a valid/ready port) by at most STEP clocks
// per frame. Optional failsafe watchdog: define SERVO_FAILSAFE_EN.

// Per-channel state: target, slewed current position, PWM pin and moving flag.
module servo_pwm_ch #(
   parameter int POS_W    = 7,
   parameter int CNT_W    = 10,
   parameter int MIN_CLKS = 100,
   parameter int STEP     = 10,
   parameter int CENTER   = 50
) (
   input  logic             i_mclk,
   input  logic             i_rst,
   input  logic             i_tick,
   input  logic             i_wr,
   input  logic [POS_W-1:0] i_wr_pos,
   input  logic             i_center,
   input  logic [CNT_W-1:0] i_cnt,
   output logic             o_servo,
   output logic             o_moving
);
   logic [POS_W-1:0] r_tgt, r_cur;
   logic [POS_W-1:0] w_diff, w_cur_nxt;
   logic             w_up;
   logic [CNT_W-1:0] w_thr;

   // Slew step: land exactly on target when within STEP, otherwise move STEP toward it.
   always_comb begin
      w_up   = (r_tgt > r_cur);
      w_diff = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
      if (32'(w_diff) <= 32'(STEP)) w_cur_nxt = r_tgt;
      else if (w_up)                w_cur_nxt = r_cur + POS_W'(STEP);
      else                          w_cur_nxt = r_cur - POS_W'(STEP);
      w_thr = CNT_W'(MIN_CLKS) + CNT_W'(r_cur);
   end

   // Target register: writes never coincide with the frame tick, so the failsafe
   // recenter (tick-only) and a write cannot collide.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst)         r_tgt <= POS_W'(CENTER);
      else if (i_wr)     r_tgt <= i_wr_pos;
      else if (i_center) r_tgt <= POS_W'(CENTER);
   end

   // Current position moves once per frame, on the counter-zero cycle.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst)       r_cur <= POS_W'(CENTER);
      else if (i_tick) r_cur <= w_cur_nxt;
   end

   // Registered pin and moving flag; the pin lags the counter by one cycle.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst) begin
         o_servo  <= 1'b0;
         o_moving <= 1'b0;
      end else begin
         o_servo  <= (i_cnt < w_thr);
         o_moving <= (r_cur != r_tgt);
      end
   end
endmodule

module servo_pwm_multi #(
   parameter int NUM_CH         = 4,
   parameter int FRAME_CLKS     = 1000000,
   parameter int MIN_CLKS       = 50000,
   parameter int MAX_CLKS       = 100000,
   parameter int STEP           = 500,
   parameter int TIMEOUT_FRAMES = 50,
   localparam int SPAN   = MAX_CLKS - MIN_CLKS,
   localparam int CENTER = SPAN / 2,
   localparam int POS_W  = $clog2(SPAN + 1),
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_mclk,
   input  logic              i_rst,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [CH_W-1:0]   i_wr_ch,
   input  logic [POS_W-1:0]  i_wr_pos,
   output logic [NUM_CH-1:0] o_servo,
   output logic [NUM_CH-1:0] o_moving,
   output logic              o_frame_tick,
   output logic              o_fault
);
   localparam int CNT_W = $clog2(FRAME_CLKS);

   logic [CNT_W-1:0] r_cnt;
   logic             w_tick, w_acc, w_center;
   logic [POS_W-1:0] w_pos_sat;

   assign w_tick     = (r_cnt == '0);
   assign o_wr_ready = ~w_tick;
   assign w_acc      = i_wr_valid & o_wr_ready;
   assign w_pos_sat  = (i_wr_pos > POS_W'(SPAN)) ? POS_W'(SPAN) : i_wr_pos;

   // Free-running frame counter, 0..FRAME_CLKS-1.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst)                                 r_cnt <= '0;
      else if (r_cnt == CNT_W'(FRAME_CLKS - 1))  r_cnt <= '0;
      else                                       r_cnt <= r_cnt + 1'b1;
   end

   // Frame tick, registered one cycle after the counter is zero.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst) o_frame_tick <= 1'b0;
      else       o_frame_tick <= w_tick;
   end

`ifdef SERVO_FAILSAFE_EN
   localparam int WD_W = $clog2(TIMEOUT_FRAMES + 1);
   logic [WD_W-1:0] r_wd;
   logic            w_ch_ok;

   assign w_ch_ok  = ({1'b0, i_wr_ch} < (CH_W + 1)'(NUM_CH));
   assign w_center = w_tick && (r_wd == WD_W'(TIMEOUT_FRAMES - 1));

   // Watchdog: frames since last valid write, saturating; trips fault when it reaches the timeout.
   always_ff @(posedge i_mclk or posedge i_rst) begin
      if (i_rst) begin
         r_wd    <= '0;
         o_fault <= 1'b0;
      end else if (w_acc && w_ch_ok) begin
         r_wd    <= '0;
         o_fault <= 1'b0;
      end else if (w_tick && (r_wd != WD_W'(TIMEOUT_FRAMES))) begin
         r_wd <= r_wd + 1'b1;
         if (w_center) o_fault <= 1'b1;
      end
   end
`else
   assign w_center = 1'b0;
   assign o_fault  = 1'b0;
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      servo_pwm_ch #(
         .POS_W(POS_W), .CNT_W(CNT_W), .MIN_CLKS(MIN_CLKS), .STEP(STEP), .CENTER(CENTER)
      ) u_ch (
         .i_mclk   (i_mclk),
         .i_rst    (i_rst),
         .i_tick   (w_tick),
         .i_wr     (w_acc && (i_wr_ch == CH_W'(i))),
         .i_wr_pos (w_pos_sat),
         .i_center (w_center),
         .i_cnt    (r_cnt),
         .o_servo  (o_servo[i]),
         .o_moving (o_moving[i])
      );
   end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: directed phases plus random writes, checked against a
// frame-level reference model (targets, slewed positions, expected pulse widths).
module tb_servo_pwm_multi;
   localparam int NCH = 2, F = 1000, MINC = 100, MAXC = 200, STP = 10, TMO = 3;
   localparam int SPAN = MAXC - MINC, CTR = SPAN / 2;

   logic       clk = 1'b0, rst = 1'b1;
   logic       wr_valid = 1'b0, wr_ready;
   logic [0:0] wr_ch = '0;
   logic [6:0] wr_pos = '0;
   logic [1:0] servo, moving;
   logic       frame_tick, fault;

   servo_pwm_multi #(
      .NUM_CH(NCH), .FRAME_CLKS(F), .MIN_CLKS(MINC), .MAX_CLKS(MAXC),
      .STEP(STP), .TIMEOUT_FRAMES(TMO)
   ) dut (
      .i_mclk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
      .i_wr_ch(wr_ch), .i_wr_pos(wr_pos), .o_servo(servo), .o_moving(moving),
      .o_frame_tick(frame_tick), .o_fault(fault)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   // reference model
   int mcnt, mcur[NCH], mtgt[NCH], mwd;
   bit mfault;
   int accw[NCH], expw[NCH], lastw[NCH];
   bit have;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mcnt = 0; mwd = 0; mfault = 0; have = 0;
      for (int i = 0; i < NCH; i++) begin
         mcur[i] = CTR; mtgt[i] = CTR; accw[i] = 0;
      end
   endtask

   // one clock: advance the model by the spec rules, then check outputs 1 time unit later
   task automatic step();
      bit acc, tick_old;
      bit [1:0] mov_exp;
      int d;
      @(posedge clk);
      acc      = wr_valid && (mcnt != 0);
      tick_old = (mcnt == 0);
      for (int i = 0; i < NCH; i++) mov_exp[i] = (mcur[i] != mtgt[i]);
      if (tick_old) begin
         for (int i = 0; i < NCH; i++) begin
            d = mtgt[i] - mcur[i];
            if (d <= STP && d >= -STP) mcur[i] = mtgt[i];
            else mcur[i] = mcur[i] + ((d > 0) ? STP : -STP);
         end
`ifdef SERVO_FAILSAFE_EN
         if (mwd < TMO) begin
            mwd++;
            if (mwd == TMO) begin
               for (int i = 0; i < NCH; i++) mtgt[i] = CTR;
               mfault = 1;
            end
         end
`endif
      end
      if (acc && int'(wr_ch) < NCH) begin
         mtgt[wr_ch] = (int'(wr_pos) > SPAN) ? SPAN : int'(wr_pos);
         mwd = 0; mfault = 0;
      end
      mcnt = (mcnt + 1) % F;
      #1;
      chk("wr_ready", 32'(wr_ready), 32'(mcnt != 0));
      chk("frame_tick", 32'(frame_tick), 32'(tick_old));
      chk("fault", 32'(fault), 32'(mfault));
      if (mcnt == F / 2) chk("moving", 32'(moving), 32'(mov_exp));
      if (mcnt == 1) begin
         for (int i = 0; i < NCH; i++) begin
            if (have) chk($sformatf("width_ch%0d", i), accw[i], expw[i]);
            lastw[i] = accw[i];
            accw[i]  = 0;
            expw[i]  = MINC + mcur[i];
         end
         have = 1;
      end
      for (int i = 0; i < NCH; i++) accw[i] += int'(servo[i]);
   endtask

   task automatic frames(int n);
      repeat (n * F) step();
   endtask

   task automatic run_to(int c);
      for (int k = 0; k <= F && mcnt != c; k++) step();
      chk("run_to", mcnt, c);
   endtask

   task automatic wr(int ch, int pos);
      bit done = 0;
      wr_valid = 1'b1; wr_ch = 1'(ch); wr_pos = 7'(pos);
      for (int k = 0; k < 4 && !done; k++) begin
         done = (mcnt != 0);
         step();
      end
      wr_valid = 1'b0;
      chk("wr_accept", 32'(done), 32'd1);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_servo", 32'(servo), 0);
      chk("rst_moving", 32'(moving), 0);
      chk("rst_tick", 32'(frame_tick), 0);
      chk("rst_ready", 32'(wr_ready), 0);
      chk("rst_fault", 32'(fault), 0);
      rst = 1'b0;

      // idle frames: centred, 150-clock pulses
      frames(3);
      chk("idle_w0", lastw[0], MINC + CTR);
      chk("idle_w1", lastw[1], MINC + CTR);

      // ch0 to full scale mid-frame: 160..200
      run_to(400);
      wr(0, 100);
      frames(7);
`ifndef SERVO_FAILSAFE_EN
      chk("full_w0", lastw[0], 200);
      chk("full_w1", lastw[1], 150);
      chk("full_mov0", 32'(moving[0]), 0);
`endif

      // saturating write then overwrite in the same frame: last wins
      wr(1, 127);
      wr(1, 0);
      frames(7);
`ifndef SERVO_FAILSAFE_EN
      chk("zero_w1", lastw[1], 100);
`endif

      // non-multiple of STEP: lands exactly without overshoot
      wr(0, 53);
      frames(7);
`ifndef SERVO_FAILSAFE_EN
      chk("exact_w0", lastw[0], 153);
`endif

      // hold valid across cnt==0: refused on that cycle, taken on the next
      run_to(0);
      wr_valid = 1'b1; wr_ch = 1'b1; wr_pos = 7'd77;
      chk("hold_ready0", 32'(wr_ready), 0);
      step();
      chk("hold_ready1", 32'(wr_ready), 1);
      step();
      wr_valid = 1'b0;
      step();
`ifndef SERVO_FAILSAFE_EN
      chk("hold_mov1", 32'(moving[1]), 1);
`endif
      frames(3);

      // random writes at random times
      for (int n = 0; n < 40; n++) begin
         repeat ($urandom_range(0, 300)) step();
         wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 127)));
      end
      frames(2);

      // asynchronous reset in the middle of a pulse
      run_to(60);
      chk("pre_rst_servo", 32'(servo), 3);
      rst = 1'b1;
      #1;
      chk("arst_servo", 32'(servo), 0);
      chk("arst_ready", 32'(wr_ready), 0);
      chk("arst_moving", 32'(moving), 0);
      chk("arst_tick", 32'(frame_tick), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      frames(3);
      chk("post_rst_w0", lastw[0], 150);
      chk("post_rst_w1", lastw[1], 150);

`ifdef SERVO_FAILSAFE_EN
      // watchdog: no writes after ch0=100 -> fault, recenter; a valid write clears it
      run_to(300);
      wr(0, 100);
      frames(4);
      chk("fs_fault", 32'(fault), 1);
      frames(8);
      chk("fs_center_w0", lastw[0], 150);
      wr(1, 20);
      chk("fs_clear", 32'(fault), 0);
      frames(1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
